// File: rtl/axi_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_reg_arbiter_if
//  Description : Bundle of every requester-side and downstream-side AXI
//                channel of the two-requester register arbiter, plus the
//                one-hot grant status outputs.
//                slave  modport : the arbiter's view (suffix _i = into the
//                                 arbiter, suffix _o = out of it).
//                master modport : the environment's view (requesters and
//                                 the downstream register slave combined).
//  Parameters  : ADDR_W address width, DATA_W data width (strobe DATA_W/8)
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_reg_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester 0
  logic [ADDR_W-1:0]   s0_awaddr_i;
  logic                s0_awvalid_i;
  logic                s0_awready_o;
  logic [DATA_W-1:0]   s0_wdata_i;
  logic [DATA_W/8-1:0] s0_wstrb_i;
  logic                s0_wvalid_i;
  logic                s0_wready_o;
  logic [1:0]          s0_bresp_o;
  logic                s0_bvalid_o;
  logic                s0_bready_i;
  logic [ADDR_W-1:0]   s0_araddr_i;
  logic                s0_arvalid_i;
  logic                s0_arready_o;
  logic [DATA_W-1:0]   s0_rdata_o;
  logic                s0_rvalid_o;
  logic                s0_rready_i;
  // requester 1
  logic [ADDR_W-1:0]   s1_awaddr_i;
  logic                s1_awvalid_i;
  logic                s1_awready_o;
  logic [DATA_W-1:0]   s1_wdata_i;
  logic [DATA_W/8-1:0] s1_wstrb_i;
  logic                s1_wvalid_i;
  logic                s1_wready_o;
  logic [1:0]          s1_bresp_o;
  logic                s1_bvalid_o;
  logic                s1_bready_i;
  logic [ADDR_W-1:0]   s1_araddr_i;
  logic                s1_arvalid_i;
  logic                s1_arready_o;
  logic [DATA_W-1:0]   s1_rdata_o;
  logic                s1_rvalid_o;
  logic                s1_rready_i;
  // downstream register slave
  logic [3:0]          m_awid_o;
  logic [ADDR_W-1:0]   m_awaddr_o;
  logic                m_awvalid_o;
  logic                m_awready_i;
  logic [DATA_W-1:0]   m_wdata_o;
  logic [DATA_W/8-1:0] m_wstrb_o;
  logic                m_wlast_o;
  logic                m_wvalid_o;
  logic                m_wready_i;
  logic [1:0]          m_bresp_i;
  logic                m_bvalid_i;
  logic                m_bready_o;
  logic [3:0]          m_arid_o;
  logic [ADDR_W-1:0]   m_araddr_o;
  logic                m_arvalid_o;
  logic                m_arready_i;
  logic [DATA_W-1:0]   m_rdata_i;
  logic                m_rvalid_i;
  logic                m_rready_o;
  // status
  logic [1:0]          w_grant_o;
  logic [1:0]          r_grant_o;

  modport slave (
    input  s0_awaddr_i, s0_awvalid_i, s0_wdata_i, s0_wstrb_i, s0_wvalid_i,
           s0_bready_i, s0_araddr_i, s0_arvalid_i, s0_rready_i,
           s1_awaddr_i, s1_awvalid_i, s1_wdata_i, s1_wstrb_i, s1_wvalid_i,
           s1_bready_i, s1_araddr_i, s1_arvalid_i, s1_rready_i,
           m_awready_i, m_wready_i, m_bresp_i, m_bvalid_i,
           m_arready_i, m_rdata_i, m_rvalid_i,
    output s0_awready_o, s0_wready_o, s0_bresp_o, s0_bvalid_o,
           s0_arready_o, s0_rdata_o, s0_rvalid_o,
           s1_awready_o, s1_wready_o, s1_bresp_o, s1_bvalid_o,
           s1_arready_o, s1_rdata_o, s1_rvalid_o,
           m_awid_o, m_awaddr_o, m_awvalid_o, m_wdata_o, m_wstrb_o,
           m_wlast_o, m_wvalid_o, m_bready_o,
           m_arid_o, m_araddr_o, m_arvalid_o, m_rready_o,
           w_grant_o, r_grant_o
  );

  modport master (
    output s0_awaddr_i, s0_awvalid_i, s0_wdata_i, s0_wstrb_i, s0_wvalid_i,
           s0_bready_i, s0_araddr_i, s0_arvalid_i, s0_rready_i,
           s1_awaddr_i, s1_awvalid_i, s1_wdata_i, s1_wstrb_i, s1_wvalid_i,
           s1_bready_i, s1_araddr_i, s1_arvalid_i, s1_rready_i,
           m_awready_i, m_wready_i, m_bresp_i, m_bvalid_i,
           m_arready_i, m_rdata_i, m_rvalid_i,
    input  s0_awready_o, s0_wready_o, s0_bresp_o, s0_bvalid_o,
           s0_arready_o, s0_rdata_o, s0_rvalid_o,
           s1_awready_o, s1_wready_o, s1_bresp_o, s1_bvalid_o,
           s1_arready_o, s1_rdata_o, s1_rvalid_o,
           m_awid_o, m_awaddr_o, m_awvalid_o, m_wdata_o, m_wstrb_o,
           m_wlast_o, m_wvalid_o, m_bready_o,
           m_arid_o, m_araddr_o, m_arvalid_o, m_rready_o,
           w_grant_o, r_grant_o
  );
endinterface
`default_nettype wire

// File: rtl/axi_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_reg_arbiter
//  Description : Two-requester arbiter in front of the AXI register slave.
//                Write and read paths are arbitrated independently, one
//                outstanding transaction per path. Responses are routed
//                back by the registered grant, not by ID.
//  Ports       : clk    - clock
//                areset - asynchronous, active-low reset
//                bus    - axi_reg_arbiter_if.slave: requester channels
//                         s0_*/s1_*, downstream channels m_*, and the
//                         one-hot grant status w_grant_o / r_grant_o
//  Config      : AXI_ARB_FIXED_PRIO_EN - when defined, requester 0 wins every
//                tie (requester 1 may starve); default is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_reg_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire                 clk,
  input  wire                 areset,
  axi_reg_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_t  r_wr_state, w_wr_state_nxt;
  logic [1:0] r_wr_grant, w_wr_grant_nxt;
  logic       r_aw_done,  w_aw_done_nxt;
  logic       r_w_done,   w_w_done_nxt;
  rd_state_t  r_rd_state, w_rd_state_nxt;
  logic [1:0] r_rd_grant, w_rd_grant_nxt;
`ifndef AXI_ARB_FIXED_PRIO_EN
  // 1 means requester 1 won the most recent arbitration on that path
  logic       r_wr_last,  w_wr_last_nxt;
  logic       r_rd_last,  w_rd_last_nxt;
`endif

  // --------------------------------------------------------------------------
  // Arbitration: one-hot pick among the requesters presenting an address
  // --------------------------------------------------------------------------
  logic       w_wr_pick0, w_rd_pick0;
  logic [1:0] w_wr_pick,  w_rd_pick;

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign w_wr_pick0 = bus.s0_awvalid_i;
  assign w_rd_pick0 = bus.s0_arvalid_i;
`else
  // On a tie requester 0 wins only if requester 1 won last time
  assign w_wr_pick0 = bus.s0_awvalid_i & (~bus.s1_awvalid_i | r_wr_last);
  assign w_rd_pick0 = bus.s0_arvalid_i & (~bus.s1_arvalid_i | r_rd_last);
`endif
  assign w_wr_pick = {bus.s1_awvalid_i & ~w_wr_pick0, w_wr_pick0};
  assign w_rd_pick = {bus.s1_arvalid_i & ~w_rd_pick0, w_rd_pick0};

  // --------------------------------------------------------------------------
  // Granted-requester muxes (selected by grant bit 1)
  // --------------------------------------------------------------------------
  logic                w_wr_sel, w_rd_sel;
  logic [ADDR_W-1:0]   w_awaddr_sel, w_araddr_sel;
  logic [DATA_W-1:0]   w_wdata_sel;
  logic [DATA_W/8-1:0] w_wstrb_sel;
  logic                w_awvalid_sel, w_wvalid_sel, w_bready_sel;
  logic                w_arvalid_sel, w_rready_sel;

  assign w_wr_sel      = r_wr_grant[1];
  assign w_rd_sel      = r_rd_grant[1];
  assign w_awaddr_sel  = w_wr_sel ? bus.s1_awaddr_i  : bus.s0_awaddr_i;
  assign w_wdata_sel   = w_wr_sel ? bus.s1_wdata_i   : bus.s0_wdata_i;
  assign w_wstrb_sel   = w_wr_sel ? bus.s1_wstrb_i   : bus.s0_wstrb_i;
  assign w_awvalid_sel = w_wr_sel ? bus.s1_awvalid_i : bus.s0_awvalid_i;
  assign w_wvalid_sel  = w_wr_sel ? bus.s1_wvalid_i  : bus.s0_wvalid_i;
  assign w_bready_sel  = w_wr_sel ? bus.s1_bready_i  : bus.s0_bready_i;
  assign w_araddr_sel  = w_rd_sel ? bus.s1_araddr_i  : bus.s0_araddr_i;
  assign w_arvalid_sel = w_rd_sel ? bus.s1_arvalid_i : bus.s0_arvalid_i;
  assign w_rready_sel  = w_rd_sel ? bus.s1_rready_i  : bus.s0_rready_i;

  assign bus.m_wlast_o  = 1'b1;
  assign bus.s0_rdata_o = bus.m_rdata_i;
  assign bus.s1_rdata_o = bus.m_rdata_i;
  assign bus.w_grant_o  = r_wr_grant;
  assign bus.r_grant_o  = r_rd_grant;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_wr_state <= W_IDLE;
      r_wr_grant <= 2'b00;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rd_state <= R_IDLE;
      r_rd_grant <= 2'b00;
`ifndef AXI_ARB_FIXED_PRIO_EN
      r_wr_last  <= 1'b1;
      r_rd_last  <= 1'b1;
`endif
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_rd_grant <= w_rd_grant_nxt;
`ifndef AXI_ARB_FIXED_PRIO_EN
      r_wr_last  <= w_wr_last_nxt;
      r_rd_last  <= w_rd_last_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Write path: next state and outputs
  // --------------------------------------------------------------------------
  logic w_aw_fire, w_w_fire;

  always_comb begin
    w_wr_state_nxt   = r_wr_state;
    w_wr_grant_nxt   = r_wr_grant;
    w_aw_done_nxt    = r_aw_done;
    w_w_done_nxt     = r_w_done;
`ifndef AXI_ARB_FIXED_PRIO_EN
    w_wr_last_nxt    = r_wr_last;
`endif
    w_aw_fire        = 1'b0;
    w_w_fire         = 1'b0;
    bus.m_awid_o     = {3'b000, r_wr_grant[1]};
    bus.m_awaddr_o   = '0;
    bus.m_awvalid_o  = 1'b0;
    bus.m_wdata_o    = '0;
    bus.m_wstrb_o    = '0;
    bus.m_wvalid_o   = 1'b0;
    bus.m_bready_o   = 1'b0;
    bus.s0_awready_o = 1'b0;
    bus.s1_awready_o = 1'b0;
    bus.s0_wready_o  = 1'b0;
    bus.s1_wready_o  = 1'b0;
    bus.s0_bvalid_o  = 1'b0;
    bus.s1_bvalid_o  = 1'b0;
    bus.s0_bresp_o   = 2'b00;
    bus.s1_bresp_o   = 2'b00;

    case (r_wr_state)
      W_IDLE: begin
        if (|w_wr_pick) begin
          w_wr_grant_nxt = w_wr_pick;
`ifndef AXI_ARB_FIXED_PRIO_EN
          w_wr_last_nxt  = w_wr_pick[1];
`endif
          w_wr_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        // Each channel is forwarded only until its own handshake so that a
        // finished channel is not issued twice while the other one stalls.
        bus.m_awaddr_o   = w_awaddr_sel;
        bus.m_awvalid_o  = w_awvalid_sel & ~r_aw_done;
        bus.m_wdata_o    = w_wdata_sel;
        bus.m_wstrb_o    = w_wstrb_sel;
        bus.m_wvalid_o   = w_wvalid_sel & ~r_w_done;
        bus.s0_awready_o = ~w_wr_sel & ~r_aw_done & bus.m_awready_i;
        bus.s1_awready_o =  w_wr_sel & ~r_aw_done & bus.m_awready_i;
        bus.s0_wready_o  = ~w_wr_sel & ~r_w_done & bus.m_wready_i;
        bus.s1_wready_o  =  w_wr_sel & ~r_w_done & bus.m_wready_i;
        w_aw_fire = w_awvalid_sel & ~r_aw_done & bus.m_awready_i;
        w_w_fire  = w_wvalid_sel & ~r_w_done & bus.m_wready_i;
        if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) begin
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_state_nxt = W_RESP;
        end else begin
          w_aw_done_nxt  = r_aw_done | w_aw_fire;
          w_w_done_nxt   = r_w_done | w_w_fire;
        end
      end
      W_RESP: begin
        bus.m_bready_o  = w_bready_sel;
        bus.s0_bvalid_o = ~w_wr_sel & bus.m_bvalid_i;
        bus.s1_bvalid_o =  w_wr_sel & bus.m_bvalid_i;
        bus.s0_bresp_o  = w_wr_sel ? 2'b00 : bus.m_bresp_i;
        bus.s1_bresp_o  = w_wr_sel ? bus.m_bresp_i : 2'b00;
        if (bus.m_bvalid_i && w_bready_sel) begin
          w_wr_grant_nxt = 2'b00;
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: begin
        w_wr_grant_nxt = 2'b00;
        w_wr_state_nxt = W_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read path: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_state_nxt   = r_rd_state;
    w_rd_grant_nxt   = r_rd_grant;
`ifndef AXI_ARB_FIXED_PRIO_EN
    w_rd_last_nxt    = r_rd_last;
`endif
    bus.m_arid_o     = {3'b000, r_rd_grant[1]};
    bus.m_araddr_o   = '0;
    bus.m_arvalid_o  = 1'b0;
    bus.m_rready_o   = 1'b0;
    bus.s0_arready_o = 1'b0;
    bus.s1_arready_o = 1'b0;
    bus.s0_rvalid_o  = 1'b0;
    bus.s1_rvalid_o  = 1'b0;

    case (r_rd_state)
      R_IDLE: begin
        if (|w_rd_pick) begin
          w_rd_grant_nxt = w_rd_pick;
`ifndef AXI_ARB_FIXED_PRIO_EN
          w_rd_last_nxt  = w_rd_pick[1];
`endif
          w_rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        bus.m_araddr_o   = w_araddr_sel;
        bus.m_arvalid_o  = w_arvalid_sel;
        bus.s0_arready_o = ~w_rd_sel & bus.m_arready_i;
        bus.s1_arready_o =  w_rd_sel & bus.m_arready_i;
        if (w_arvalid_sel && bus.m_arready_i) begin
          w_rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        bus.m_rready_o  = w_rready_sel;
        bus.s0_rvalid_o = ~w_rd_sel & bus.m_rvalid_i;
        bus.s1_rvalid_o =  w_rd_sel & bus.m_rvalid_i;
        if (bus.m_rvalid_i && w_rready_sel) begin
          w_rd_grant_nxt = 2'b00;
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: begin
        w_rd_grant_nxt = 2'b00;
        w_rd_state_nxt = R_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_reg_arbiter
//  Description : Directed self-checking bench for axi_reg_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_reg_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic areset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axi_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  // every valid/ready the arbiter drives
  function automatic logic [14:0] all_vr();
    return {bus.s0_awready_o, bus.s0_wready_o, bus.s0_bvalid_o, bus.s0_arready_o, bus.s0_rvalid_o,
            bus.s1_awready_o, bus.s1_wready_o, bus.s1_bvalid_o, bus.s1_arready_o, bus.s1_rvalid_o,
            bus.m_awvalid_o, bus.m_wvalid_o, bus.m_bready_o, bus.m_arvalid_o, bus.m_rready_o};
  endfunction

  function automatic logic [4:0] s1_vr();
    return {bus.s1_awready_o, bus.s1_wready_o, bus.s1_bvalid_o, bus.s1_arready_o, bus.s1_rvalid_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.s0_awaddr_i = '0; bus.s0_awvalid_i = 0; bus.s0_wdata_i = '0; bus.s0_wstrb_i = '0;
    bus.s0_wvalid_i = 0;  bus.s0_bready_i = 0;  bus.s0_araddr_i = '0; bus.s0_arvalid_i = 0;
    bus.s0_rready_i = 0;
    bus.s1_awaddr_i = '0; bus.s1_awvalid_i = 0; bus.s1_wdata_i = '0; bus.s1_wstrb_i = '0;
    bus.s1_wvalid_i = 0;  bus.s1_bready_i = 0;  bus.s1_araddr_i = '0; bus.s1_arvalid_i = 0;
    bus.s1_rready_i = 0;
    bus.m_awready_i = 0;  bus.m_wready_i = 0;   bus.m_bresp_i = 2'b00; bus.m_bvalid_i = 0;
    bus.m_arready_i = 0;  bus.m_rdata_i = '0;   bus.m_rvalid_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b0;
    tick();
    tick();
    areset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.s0_awaddr_i = 32'h55; bus.s0_wdata_i = 32'hAA; bus.s1_araddr_i = 32'h77;
    areset = 1'b0;
    tick();
    tick();
    checks++; if (all_vr() !== 15'h0) begin failures++; $display("FAIL reset_valid_ready got=%h exp=%h", all_vr(), 15'h0); end
    checks++; if (bus.w_grant_o !== 2'b00 || bus.r_grant_o !== 2'b00) begin failures++; $display("FAIL reset_grants got=%b/%b exp=00/00", bus.w_grant_o, bus.r_grant_o); end
    checks++; if (bus.m_awaddr_o !== 32'h0 || bus.m_wdata_o !== 32'h0 || bus.m_araddr_o !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h/%h/%h exp=0", bus.m_awaddr_o, bus.m_wdata_o, bus.m_araddr_o); end
    checks++; if (bus.m_awid_o !== 4'h0 || bus.m_arid_o !== 4'h0) begin failures++; $display("FAIL reset_ids got=%h/%h exp=0/0", bus.m_awid_o, bus.m_arid_o); end
    checks++; if (bus.m_wlast_o !== 1'b1) begin failures++; $display("FAIL reset_wlast got=%b exp=1", bus.m_wlast_o); end
    areset = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    bus.s0_awaddr_i = 32'h4; bus.s0_awvalid_i = 1; bus.s0_wdata_i = 32'hDEADBEEF;
    bus.s0_wstrb_i = 4'hF; bus.s0_wvalid_i = 1; bus.s0_bready_i = 1;
    bus.m_awready_i = 1; bus.m_wready_i = 1;
    #1;
    checks++; if (bus.m_awvalid_o !== 1'b0) begin failures++; $display("FAIL single_idle_awvalid got=%b exp=0", bus.m_awvalid_o); end
    tick();
    checks++; if (bus.w_grant_o !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", bus.w_grant_o); end
    checks++; if (bus.m_awvalid_o !== 1'b1 || bus.m_awaddr_o !== 32'h4 || bus.m_awid_o !== 4'h0) begin failures++; $display("FAIL single_aw got=%b/%h/%h exp=1/4/0", bus.m_awvalid_o, bus.m_awaddr_o, bus.m_awid_o); end
    checks++; if (bus.m_wvalid_o !== 1'b1 || bus.m_wdata_o !== 32'hDEADBEEF || bus.m_wstrb_o !== 4'hF) begin failures++; $display("FAIL single_w got=%b/%h/%h exp=1/deadbeef/f", bus.m_wvalid_o, bus.m_wdata_o, bus.m_wstrb_o); end
    checks++; if (bus.s0_awready_o !== 1'b1 || bus.s0_wready_o !== 1'b1) begin failures++; $display("FAIL single_s0_ready got=%b/%b exp=1/1", bus.s0_awready_o, bus.s0_wready_o); end
    checks++; if (s1_vr() !== 5'b0) begin failures++; $display("FAIL single_s1_quiet_addr got=%b exp=00000", s1_vr()); end
    tick();
    bus.s0_awvalid_i = 0; bus.s0_wvalid_i = 0; bus.m_bvalid_i = 1; bus.m_bresp_i = 2'b00;
    #1;
    checks++; if (bus.m_awvalid_o !== 1'b0 || bus.m_bready_o !== 1'b1) begin failures++; $display("FAIL single_resp_ctl got=%b/%b exp=0/1", bus.m_awvalid_o, bus.m_bready_o); end
    checks++; if (bus.s0_bvalid_o !== 1'b1 || bus.s0_bresp_o !== 2'b00) begin failures++; $display("FAIL single_s0_b got=%b/%b exp=1/00", bus.s0_bvalid_o, bus.s0_bresp_o); end
    checks++; if (s1_vr() !== 5'b0) begin failures++; $display("FAIL single_s1_quiet_resp got=%b exp=00000", s1_vr()); end
    tick();
    bus.m_bvalid_i = 0;
    #1;
    checks++; if (bus.w_grant_o !== 2'b00 || bus.s0_bvalid_o !== 1'b0) begin failures++; $display("FAIL single_done got=%b/%b exp=00/0", bus.w_grant_o, bus.s0_bvalid_o); end
  endtask

  task automatic test_tie();
    do_reset();
    bus.s0_awaddr_i = 32'h10; bus.s0_wdata_i = 32'h11; bus.s0_awvalid_i = 1; bus.s0_wvalid_i = 1;
    bus.s1_awaddr_i = 32'h20; bus.s1_wdata_i = 32'h21; bus.s1_awvalid_i = 1; bus.s1_wvalid_i = 1;
    bus.s0_bready_i = 1; bus.s1_bready_i = 1; bus.m_awready_i = 1; bus.m_wready_i = 1;
    tick();
    checks++; if (bus.w_grant_o !== 2'b01 || bus.m_awaddr_o !== 32'h10) begin failures++; $display("FAIL tie_first got=%b/%h exp=01/10", bus.w_grant_o, bus.m_awaddr_o); end
    checks++; if (bus.s1_awready_o !== 1'b0 || bus.s1_wready_o !== 1'b0) begin failures++; $display("FAIL tie_s1_blocked got=%b/%b exp=0/0", bus.s1_awready_o, bus.s1_wready_o); end
    tick();
    bus.s0_awvalid_i = 0; bus.s0_wvalid_i = 0; bus.m_bvalid_i = 1;
    #1;
    checks++; if (bus.s0_bvalid_o !== 1'b1 || bus.s1_bvalid_o !== 1'b0) begin failures++; $display("FAIL tie_first_b got=%b/%b exp=1/0", bus.s0_bvalid_o, bus.s1_bvalid_o); end
    tick();
    bus.m_bvalid_i = 0;
    #1;
    checks++; if (bus.w_grant_o !== 2'b00 || bus.m_awvalid_o !== 1'b0) begin failures++; $display("FAIL tie_idle_gap got=%b/%b exp=00/0", bus.w_grant_o, bus.m_awvalid_o); end
    tick();
    checks++; if (bus.w_grant_o !== 2'b10 || bus.m_awaddr_o !== 32'h20 || bus.m_awid_o !== 4'h1 || bus.m_wdata_o !== 32'h21) begin failures++; $display("FAIL tie_second got=%b/%h/%h/%h exp=10/20/1/21", bus.w_grant_o, bus.m_awaddr_o, bus.m_awid_o, bus.m_wdata_o); end
    checks++; if (bus.s1_awready_o !== 1'b1 || bus.s0_awready_o !== 1'b0) begin failures++; $display("FAIL tie_second_ready got=%b/%b exp=1/0", bus.s1_awready_o, bus.s0_awready_o); end
    tick();
    bus.s1_awvalid_i = 0; bus.s1_wvalid_i = 0; bus.m_bvalid_i = 1;
    #1;
    checks++; if (bus.s1_bvalid_o !== 1'b1 || bus.s0_bvalid_o !== 1'b0) begin failures++; $display("FAIL tie_second_b got=%b/%b exp=1/0", bus.s1_bvalid_o, bus.s0_bvalid_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int exp_idx[4];
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_idx = '{0, 0, 0, 0};
`else
    exp_idx = '{0, 1, 0, 1};
`endif
    do_reset();
    bus.s0_awvalid_i = 1; bus.s0_wvalid_i = 1; bus.s1_awvalid_i = 1; bus.s1_wvalid_i = 1;
    bus.s0_bready_i = 1; bus.s1_bready_i = 1; bus.m_awready_i = 1; bus.m_wready_i = 1;
    bus.m_bvalid_i = 1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (bus.w_grant_o === 2'b00 && n < 10) begin tick(); n++; end
      checks++; if (bus.w_grant_o !== (2'b01 << exp_idx[i])) begin failures++; $display("FAIL b2b_order[%0d] got=%b exp=%b", i, bus.w_grant_o, 2'b01 << exp_idx[i]); end
      n = 0;
      while (bus.w_grant_o !== 2'b00 && n < 10) begin tick(); n++; end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_concurrent();
    do_reset();
    bus.s1_araddr_i = 32'h2; bus.s1_arvalid_i = 1; bus.s1_rready_i = 1;
    bus.s0_awaddr_i = 32'h8; bus.s0_awvalid_i = 1; bus.s0_wdata_i = 32'h5; bus.s0_wvalid_i = 1;
    bus.s0_bready_i = 1; bus.m_arready_i = 1; bus.m_awready_i = 1; bus.m_wready_i = 1;
    tick();
    checks++; if (bus.r_grant_o !== 2'b10 || bus.w_grant_o !== 2'b01) begin failures++; $display("FAIL conc_grants got=%b/%b exp=10/01", bus.r_grant_o, bus.w_grant_o); end
    checks++; if (bus.m_arvalid_o !== 1'b1 || bus.m_araddr_o !== 32'h2 || bus.m_arid_o !== 4'h1) begin failures++; $display("FAIL conc_ar got=%b/%h/%h exp=1/2/1", bus.m_arvalid_o, bus.m_araddr_o, bus.m_arid_o); end
    checks++; if (bus.s1_arready_o !== 1'b1 || bus.s0_arready_o !== 1'b0) begin failures++; $display("FAIL conc_arready got=%b/%b exp=1/0", bus.s1_arready_o, bus.s0_arready_o); end
    tick();
    bus.s1_arvalid_i = 0; bus.s0_awvalid_i = 0; bus.s0_wvalid_i = 0;
    bus.m_rvalid_i = 1; bus.m_rdata_i = 32'hCAFE1234; bus.m_bvalid_i = 1; bus.m_bresp_i = 2'b10;
    #1;
    checks++; if (bus.s1_rvalid_o !== 1'b1 || bus.s1_rdata_o !== 32'hCAFE1234 || bus.m_rready_o !== 1'b1) begin failures++; $display("FAIL conc_s1_r got=%b/%h/%b exp=1/cafe1234/1", bus.s1_rvalid_o, bus.s1_rdata_o, bus.m_rready_o); end
    checks++; if (bus.s0_rvalid_o !== 1'b0 || bus.s0_rdata_o !== 32'hCAFE1234) begin failures++; $display("FAIL conc_s0_r got=%b/%h exp=0/cafe1234", bus.s0_rvalid_o, bus.s0_rdata_o); end
    checks++; if (bus.s0_bvalid_o !== 1'b1 || bus.s0_bresp_o !== 2'b10 || bus.s1_bvalid_o !== 1'b0) begin failures++; $display("FAIL conc_s0_b got=%b/%b/%b exp=1/10/0", bus.s0_bvalid_o, bus.s0_bresp_o, bus.s1_bvalid_o); end
    tick();
    bus.m_rvalid_i = 0; bus.m_bvalid_i = 0;
    #1;
    checks++; if (bus.r_grant_o !== 2'b00 || bus.w_grant_o !== 2'b00) begin failures++; $display("FAIL conc_release got=%b/%b exp=00/00", bus.r_grant_o, bus.w_grant_o); end
    clear_inputs();
  endtask

  task automatic test_w_before_aw();
    int bpulses = 0;
    do_reset();
    bus.s0_awaddr_i = 32'hC; bus.s0_awvalid_i = 1; bus.s0_wdata_i = 32'h9; bus.s0_wvalid_i = 1;
    bus.s0_bready_i = 1; bus.m_wready_i = 1; bus.m_awready_i = 0; bus.m_bvalid_i = 1;
    tick();   // W_ADDR, first address cycle: W handshakes this cycle
    if (bus.s0_bvalid_o === 1'b1) bpulses++;
    checks++; if (bus.m_awvalid_o !== 1'b1 || bus.m_wvalid_o !== 1'b1 || bus.m_bready_o !== 1'b0) begin failures++; $display("FAIL wfirst_c1 got=%b/%b/%b exp=1/1/0", bus.m_awvalid_o, bus.m_wvalid_o, bus.m_bready_o); end
    tick();
    bus.s0_wvalid_i = 0;
    #1;
    if (bus.s0_bvalid_o === 1'b1) bpulses++;
    checks++; if (bus.m_wvalid_o !== 1'b0 || bus.s0_wready_o !== 1'b0 || bus.m_awvalid_o !== 1'b1) begin failures++; $display("FAIL wfirst_c2 got=%b/%b/%b exp=0/0/1", bus.m_wvalid_o, bus.s0_wready_o, bus.m_awvalid_o); end
    tick();
    bus.m_awready_i = 1;
    #1;
    if (bus.s0_bvalid_o === 1'b1) bpulses++;
    checks++; if (bus.m_awvalid_o !== 1'b1 || bus.m_bready_o !== 1'b0 || bus.s0_awready_o !== 1'b1) begin failures++; $display("FAIL wfirst_c3 got=%b/%b/%b exp=1/0/1", bus.m_awvalid_o, bus.m_bready_o, bus.s0_awready_o); end
    tick();
    bus.s0_awvalid_i = 0; bus.m_awready_i = 0;
    #1;
    checks++; if (bus.s0_bvalid_o !== 1'b1 || bus.m_bready_o !== 1'b1) begin failures++; $display("FAIL wfirst_resp got=%b/%b exp=1/1", bus.s0_bvalid_o, bus.m_bready_o); end
    if (bus.s0_bvalid_o === 1'b1) bpulses++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.s0_bvalid_o === 1'b1) bpulses++;
    end
    checks++; if (bpulses !== 1) begin failures++; $display("FAIL wfirst_bpulses got=%0d exp=1", bpulses); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.s0_awvalid_i = 1; bus.s0_wvalid_i = 1; bus.s0_bready_i = 1;
    bus.m_awready_i = 1; bus.m_wready_i = 1;
    tick();
    tick();
    bus.s0_awvalid_i = 0; bus.s0_wvalid_i = 0; bus.m_bvalid_i = 1;
    #1;
    checks++; if (bus.s0_bvalid_o !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", bus.s0_bvalid_o); end
    areset = 1'b0;
    #1;
    checks++; if (all_vr() !== 15'h0) begin failures++; $display("FAIL midrst_valid_ready got=%h exp=%h", all_vr(), 15'h0); end
    checks++; if (bus.w_grant_o !== 2'b00 || bus.r_grant_o !== 2'b00) begin failures++; $display("FAIL midrst_grants got=%b/%b exp=00/00", bus.w_grant_o, bus.r_grant_o); end
    clear_inputs();
    tick();
    areset = 1'b1;
    bus.s1_awaddr_i = 32'h30; bus.s1_awvalid_i = 1; bus.s1_wvalid_i = 1;
    tick();
    checks++; if (bus.w_grant_o !== 2'b10 || bus.m_awaddr_o !== 32'h30) begin failures++; $display("FAIL midrst_regrant got=%b/%h exp=10/30", bus.w_grant_o, bus.m_awaddr_o); end
    clear_inputs();
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_concurrent();
    test_w_before_aw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/axi_reg_arbiter.md
# axi_reg_arbiter

Two-requester arbiter in front of the AXI register slave. It lets two AXI masters share the single register-file port, for example a CPU bridge and the counter sequencer. Write and read paths are arbitrated independently, with one outstanding transaction per path. Responses are routed back by the registered grant, not by ID.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports (N = 0, 1; "/" separates signals on the same channel):
- clk  in  1  clock
- areset  in  1  reset, asynchronous, active-low
- sN_aw: sN_awaddr_i in ADDR_W / sN_awvalid_i in 1 / sN_awready_o out 1  requester write address
- sN_w: sN_wdata_i in DATA_W / sN_wstrb_i in DATA_W/8 / sN_wvalid_i in 1 / sN_wready_o out 1  requester write data
- sN_b: sN_bresp_o out 2 / sN_bvalid_o out 1 / sN_bready_i in 1  requester write response
- sN_ar: sN_araddr_i in ADDR_W / sN_arvalid_i in 1 / sN_arready_o out 1  requester read address
- sN_r: sN_rdata_o out DATA_W / sN_rvalid_o out 1 / sN_rready_i in 1  requester read data
- m_aw: m_awid_o out 4 / m_awaddr_o out ADDR_W / m_awvalid_o out 1 / m_awready_i in 1  downstream write address
- m_w: m_wdata_o out DATA_W / m_wstrb_o out DATA_W/8 / m_wlast_o out 1 / m_wvalid_o out 1 / m_wready_i in 1  downstream write data
- m_b: m_bresp_i in 2 / m_bvalid_i in 1 / m_bready_o out 1  downstream write response
- m_ar: m_arid_o out 4 / m_araddr_o out ADDR_W / m_arvalid_o out 1 / m_arready_i in 1  downstream read address
- m_r: m_rdata_i in DATA_W / m_rvalid_i in 1 / m_rready_o out 1  downstream read data
- w_grant_o out 2 / r_grant_o out 2  one-hot current grant (status)

## Operation
- Write FSM states are W_IDLE, W_ADDR and W_RESP; the read FSM is R_IDLE, R_ADDR and R_DATA, with identical structure.
- W_IDLE: requester N is a candidate when sN_awvalid_i=1; wvalid is not required.
  - With one candidate, that candidate is granted.
  - With two candidates, the requester other than last_w is granted.
  - The grant is registered, last_w is updated to the winner, and the FSM moves to W_ADDR.
- W_ADDR: the granted requester's AW and W channels pass combinationally to m_aw and m_w. The granted sN_awready_o and sN_wready_o mirror m_awready_i and m_wready_i.
  - The aw_done and w_done flags are set on the respective downstream handshakes.
  - The FSM moves to W_RESP when both flags are done, including when both handshakes land in the same cycle. The flags clear on that transition.
- W_RESP: m_bready_o equals the granted sN_bready_i. The granted sN_bvalid_o equals m_bvalid_i, and sN_bresp_o equals m_bresp_i. On the m_b handshake the grant clears and the FSM returns to W_IDLE.
- The read path follows the same pattern: R_ADDR forwards AR until the m_ar handshake; R_DATA forwards R until the m_r handshake.
- The non-granted requester always sees ready=0 and valid=0.
- m_awid_o and m_arid_o carry the granted index (0 or 1, zero-extended to 4 bits). m_wlast_o is tied to 1.
- sN_rdata_o is m_rdata_i broadcast to both requesters; only rvalid is gated by the grant.
- The write and read FSMs are fully independent, so one read and one write may be in flight concurrently.
- Requesters must hold valid until ready, as AXI requires. Withdrawing valid leaves the FSM in the ADDR state.

## Timing
- Reset (areset=0, asynchronous) puts both FSMs in IDLE with grants = 2'b00, last_w = last_r = 1, and all done flags = 0.
  - Every valid and ready output is 0, every m_ data, address and id output is 0, and m_wlast_o = 1.
- Latency: request seen in IDLE at cycle 0 → grant registered at edge 1 → m_awvalid_o/m_arvalid_o high in cycle 1. The arbiter adds no further latency; all forwarding is combinational.
- After a response handshake the FSM spends one cycle in IDLE before the next grant, so the minimum issue interval is 1 idle cycle per transaction.
- When areset asserts mid-transaction, the outstanding transaction is dropped without a response; requesters and the slave are reset together.

## Configuration
- AXI_ARB_FIXED_PRIO_EN:
  - Defined: on a tie, requester 0 always wins and last_w/last_r are unused. Requester 1 can starve.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Single s0 write, awaddr=0x4, wdata=0xDEADBEEF, wstrb=0xF → m_awaddr_o=0x4, m_awid_o=0, m_wdata_o=0xDEADBEEF, w_grant_o=01. s0_bvalid_o follows m_bvalid_i with bresp 0; s1 outputs stay 0.
- s0 and s1 both assert awvalid in the first cycle after reset → s0 is served first (w_grant_o=01), then s1 (10), one idle cycle apart.
- Both requesters write continuously for 4 transactions → grant order 0,1,0,1. With AXI_ARB_FIXED_PRIO_EN defined → 0,0,0,0.
- s1 read at araddr=0x2 concurrent with s0 write → r_grant_o=10 and w_grant_o=01 in the same cycle. s1 receives m_rdata_i with rvalid; s0 receives its b response.
- Granted s0 presents W two cycles before AW, and m_awready_i is delayed 3 cycles → W_RESP is entered only after both handshakes; exactly one bvalid pulse reaches s0.
- areset asserted while in W_RESP → all valid and ready outputs are 0 immediately and grants are 00. After release, the first s1 request is granted in 1 cycle.
